// File: rtl/cmd_decoder_pkg.sv
// Shared constants for the host command decoder: ASCII tokens, frame offsets,
// minimum frame lengths and chirp register reset values.
package cmd_decoder_pkg;

  localparam logic [7:0] ASCII_C = 8'h43;
  localparam logic [7:0] ASCII_W = 8'h57;
  localparam logic [7:0] ASCII_R = 8'h52;

  // Byte offsets from the first beat of a frame (6-bit to match the byte counter)
  localparam logic [5:0] OFS_SRC  = 6'd6;
  localparam logic [5:0] OFS_TYPE = 6'd16;
  localparam logic [5:0] OFS_OP   = 6'd18;
  localparam logic [5:0] OFS_ID   = 6'd20;
  localparam logic [5:0] OFS_DATA = 6'd24;

  localparam logic [5:0] MIN_LEN_WR = 6'd52;
  localparam logic [5:0] MIN_LEN_RD = 6'd24;
  localparam logic [5:0] RESP_LAST  = 6'd51;

  localparam logic [31:0] REG2_INIT = 32'd200;
  localparam logic [31:0] REG3_INIT = 32'h0000_0300;
  localparam logic [31:0] REG4_INIT = 32'd1;
  localparam logic [31:0] REG5_INIT = 32'h0000_1000;
  localparam logic [31:0] REG6_INIT = 32'd1;

  typedef enum logic [2:0] {RX_IDLE, RX_HDR, RX_DATA, RX_DROP, TX_SEND} state_e;
  typedef enum logic [1:0] {OP_NONE, OP_WR, OP_RD} op_e;

  function automatic logic [223:0] regs_init(input logic [31:0] r0, input logic [31:0] r1);
    return {REG6_INIT, REG5_INIT, REG4_INIT, REG3_INIT, REG2_INIT, r1, r0};
  endfunction

  // Byte-reverse a MAC so that, in a little-endian packed frame, the MSB goes out first.
  function automatic logic [47:0] mac_wire_order(input logic [47:0] m);
    return {m[7:0], m[15:8], m[23:16], m[31:24], m[39:32], m[47:40]};
  endfunction

endpackage

// File: rtl/cmd_decoder_resp_tx.sv
// Response serializer: snapshots a 52-byte read-response frame on start and
// streams it out on AXI-Stream, holding tdata/tvalid while tready is low.
module cmd_resp_tx #(
  parameter logic [47:0] SRC_MAC = 48'h5a0102030405
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [47:0]  dst_mac,
  input  logic [31:0]  cmd_id,
  input  logic [223:0] regs,
  output logic [7:0]   tdata,
  output logic         tvalid,
  output logic         tlast,
  input  logic         tready,
  output logic         done
);
  import cmd_decoder_pkg::*;

  logic [415:0] frame_q, frame_d;
  logic [5:0]   idx_q, idx_d;
  logic         valid_q, valid_d;

  // Handshake: a byte transfers on a cycle with tvalid & tready both high.
  always_comb begin
    frame_d = frame_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (start) begin
      frame_d = {regs, cmd_id, ASCII_R, ASCII_R, ASCII_C, ASCII_C,
                 8'h00, 8'h00, 8'h26, 8'h00,
                 mac_wire_order(SRC_MAC), mac_wire_order(dst_mac)};
      idx_d   = '0;
      valid_d = 1'b1;
    end else if (valid_q && tready) begin
      if (idx_q == RESP_LAST) begin
        idx_d   = '0;
        valid_d = 1'b0;
      end else begin
        idx_d = idx_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      frame_q <= frame_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign tdata  = valid_q ? frame_q[{idx_q, 3'b000} +: 8] : 8'h00;
  assign tvalid = valid_q;
  assign tlast  = valid_q && (idx_q == RESP_LAST);
  assign done   = valid_q && tready && (idx_q == RESP_LAST);

endmodule

// File: rtl/cmd_decoder.sv
// Host command decoder: parses "CC" write/read frames from the MAC rx stream,
// atomically updates the chirp register bank and queues read responses.
module cmd_decoder #(
  parameter bit          SIMULATION                = 1'b0,
  parameter logic [47:0] FPGA_MAC_ADDR             = 48'h5a0102030405,
  parameter logic [31:0] CHIRP_PRF_INT_COUNT_INIT  = 32'h00000000,
  parameter logic [31:0] CHIRP_PRF_FRAC_COUNT_INIT = 32'h927c0000
) (
  input  logic         gtx_clk_bufg,
  input  logic         gtx_resetn,
  input  logic [7:0]   gpio_dip_sw,
  output logic [7:0]   gpio_led,
  input  logic [7:0]   rx_axis_tdata,
  input  logic         rx_axis_tvalid,
  input  logic         rx_axis_tlast,
  output logic         rx_axis_tready,
  output logic [7:0]   tx_axis_tdata,
  output logic         tx_axis_tvalid,
  output logic         tx_axis_tlast,
  input  logic         tx_axis_tready,
  output logic [223:0] chirp_regs,
  output logic         cmd_update
);
  import cmd_decoder_pkg::*;

  localparam int HB_W = SIMULATION ? 6 : 26;
  localparam logic [223:0] REGS_INIT = regs_init(CHIRP_PRF_INT_COUNT_INIT, CHIRP_PRF_FRAC_COUNT_INIT);

  state_e         state_q, state_d;
  op_e            op_q, op_d;
  logic [5:0]     cnt_q, cnt_d;
  logic [7:0]     op0_q, op0_d;
  logic [47:0]    src_q, src_d;
  logic [31:0]    id_q, id_d;
  logic [223:0]   shadow_q, shadow_d;
  logic [223:0]   regs_q, regs_d;
  logic           upd_q, upd_d, start_q, start_d, err_q, err_d;
  logic           rd_tgl_q, rd_tgl_d, wr_tgl_q, wr_tgl_d;
  logic [3:0]     led_id_q, led_id_d;
  logic [HB_W-1:0] hb_q, hb_d;
  logic           beat, exec_wr, exec_rd, tx_done;
  logic [7:0]     mac_byte;
  logic           dip_unused;

  assign dip_unused = ^gpio_dip_sw[7:1];
  assign rx_axis_tready = (state_q != TX_SEND);
  assign beat = rx_axis_tvalid && rx_axis_tready;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    op0_d    = op0_q;
    src_d    = src_q;
    id_d     = id_q;
    shadow_d = shadow_q;
    regs_d   = regs_q;
    upd_d    = 1'b0;
    start_d  = 1'b0;
    err_d    = err_q;
    rd_tgl_d = rd_tgl_q;
    wr_tgl_d = wr_tgl_q;
    led_id_d = led_id_q;
    hb_d     = hb_q + HB_W'(1);
    exec_wr  = 1'b0;
    exec_rd  = 1'b0;
    mac_byte = 8'h00;
    for (int i = 0; i < 6; i++)
      if (cnt_q == 6'(i)) mac_byte = FPGA_MAC_ADDR[8*(5-i) +: 8];

    if (beat)
      cnt_d = rx_axis_tlast ? 6'd0 : ((cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1);

    case (state_q)
      RX_IDLE, RX_HDR: begin
        if (beat) begin
          state_d = RX_HDR;
          if (cnt_q < OFS_SRC && rx_axis_tdata != mac_byte) begin
            err_d   = 1'b1;
            state_d = RX_DROP;
          end
          for (int i = 0; i < 6; i++)
            if (cnt_q == OFS_SRC + 6'(i)) src_d[8*(5-i) +: 8] = rx_axis_tdata;
          if ((cnt_q == OFS_TYPE || cnt_q == OFS_TYPE + 6'd1) && rx_axis_tdata != ASCII_C)
            state_d = RX_DROP;
          if (cnt_q == OFS_OP) op0_d = rx_axis_tdata;
          if (cnt_q == OFS_OP + 6'd1) begin
            if (op0_q == ASCII_W && rx_axis_tdata == ASCII_W) op_d = OP_WR;
            else if (op0_q == ASCII_R && rx_axis_tdata == ASCII_R) op_d = OP_RD;
            else begin
              op_d    = OP_NONE;
              state_d = RX_DROP;
            end
          end
          for (int i = 0; i < 4; i++)
            if (cnt_q == OFS_ID + 6'(i)) id_d[8*i +: 8] = rx_axis_tdata;
          if (cnt_q == OFS_DATA - 6'd1 && state_d == RX_HDR) state_d = RX_DATA;
          // A frame that ends inside the header is only valid as a minimum-length read.
          if (rx_axis_tlast) begin
            if (state_d != RX_DROP) begin
              if (cnt_q == MIN_LEN_RD - 6'd1 && op_d == OP_RD) exec_rd = 1'b1;
              else err_d = 1'b1;
            end
            state_d = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (beat) begin
          if (op_q == OP_WR)
            for (int i = 0; i < 28; i++)
              if (cnt_q == OFS_DATA + 6'(i)) shadow_d[8*i +: 8] = rx_axis_tdata;
          if (rx_axis_tlast) begin
            state_d = RX_IDLE;
            if (op_q == OP_RD) exec_rd = 1'b1;
            else if (cnt_q >= MIN_LEN_WR - 6'd1) exec_wr = 1'b1;
            else err_d = 1'b1;
          end
        end
      end
      RX_DROP: begin
        if (beat && rx_axis_tlast) state_d = RX_IDLE;
      end
      TX_SEND: begin
        if (tx_done) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase

    // shadow_d already holds the final data byte when tlast arrives on byte 51.
    if (exec_wr && gpio_dip_sw[0]) begin
      regs_d   = shadow_d;
      upd_d    = 1'b1;
      wr_tgl_d = ~wr_tgl_q;
      led_id_d = id_q[3:0];
    end
    if (exec_rd && gpio_dip_sw[0]) begin
      state_d  = TX_SEND;
      start_d  = 1'b1;
      rd_tgl_d = ~rd_tgl_q;
      led_id_d = id_q[3:0];
    end
  end

  always_ff @(posedge gtx_clk_bufg or negedge gtx_resetn) begin
    if (!gtx_resetn) begin
      state_q  <= RX_IDLE;
      op_q     <= OP_NONE;
      cnt_q    <= '0;
      op0_q    <= '0;
      src_q    <= '0;
      id_q     <= '0;
      shadow_q <= '0;
      regs_q   <= REGS_INIT;
      upd_q    <= 1'b0;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
      rd_tgl_q <= 1'b0;
      wr_tgl_q <= 1'b0;
      led_id_q <= '0;
      hb_q     <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      op0_q    <= op0_d;
      src_q    <= src_d;
      id_q     <= id_d;
      shadow_q <= shadow_d;
      regs_q   <= regs_d;
      upd_q    <= upd_d;
      start_q  <= start_d;
      err_q    <= err_d;
      rd_tgl_q <= rd_tgl_d;
      wr_tgl_q <= wr_tgl_d;
      led_id_q <= led_id_d;
      hb_q     <= hb_d;
    end
  end

  cmd_resp_tx #(.SRC_MAC(FPGA_MAC_ADDR)) u_resp_tx (
    .clk     (gtx_clk_bufg),
    .rst_n   (gtx_resetn),
    .start   (start_q),
    .dst_mac (src_q),
    .cmd_id  (id_q),
    .regs    (regs_q),
    .tdata   (tx_axis_tdata),
    .tvalid  (tx_axis_tvalid),
    .tlast   (tx_axis_tlast),
    .tready  (tx_axis_tready),
    .done    (tx_done)
  );

  assign chirp_regs = regs_q;
  assign cmd_update = upd_q;
  assign gpio_led   = {led_id_q, err_q, rd_tgl_q, wr_tgl_q, hb_q[HB_W-1]};

endmodule

// File: tb/tb_cmd_decoder.sv
// Directed bench for cmd_decoder: write/read frames, discard cases, tx backpressure
// and mid-frame reset, with a byte scoreboard on the response stream.
module tb_cmd_decoder;

  localparam logic [47:0] FPGA_MAC = 48'h5a0102030405;
  localparam logic [47:0] HOST_MAC = 48'h985aebdb066f;
  localparam logic [7:0]  C_ = 8'h43, W_ = 8'h57, R_ = 8'h52, X_ = 8'h58;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   dip_sw = 8'h01;
  logic [7:0]   led;
  logic [7:0]   rx_tdata = 8'h00;
  logic         rx_tvalid = 1'b0, rx_tlast = 1'b0, rx_tready;
  logic [7:0]   tx_tdata;
  logic         tx_tvalid, tx_tlast;
  logic         tx_tready = 1'b1;
  logic [223:0] regs;
  logic         upd;

  int n_chk = 0, n_err = 0;
  int upd_cnt = 0, exp_upd = 0, unexpected = 0, tx_idx = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  fb[64];
  logic [31:0] m_regs[7];
  logic [3:0]  m_id = 4'h0;
  logic        m_err = 1'b0, m_rd = 1'b0, m_wr = 1'b0;
  bit          stall_prev = 1'b0;
  logic [7:0]  held = 8'h00;

  cmd_decoder #(.SIMULATION(1'b1)) dut (
    .gtx_clk_bufg   (clk),
    .gtx_resetn     (rst_n),
    .gpio_dip_sw    (dip_sw),
    .gpio_led       (led),
    .rx_axis_tdata  (rx_tdata),
    .rx_axis_tvalid (rx_tvalid),
    .rx_axis_tlast  (rx_tlast),
    .rx_axis_tready (rx_tready),
    .tx_axis_tdata  (tx_tdata),
    .tx_axis_tvalid (tx_tvalid),
    .tx_axis_tlast  (tx_tlast),
    .tx_axis_tready (tx_tready),
    .chirp_regs     (regs),
    .cmd_update     (upd)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [223:0] pack_regs();
    logic [223:0] r;
    for (int k = 0; k < 7; k++) r[32*k +: 32] = m_regs[k];
    return r;
  endfunction

  task automatic model_reset();
    m_regs = '{32'h0, 32'h927c0000, 32'd200, 32'h300, 32'd1, 32'h1000, 32'd1};
    m_id = 4'h0; m_err = 1'b0; m_rd = 1'b0; m_wr = 1'b0;
  endtask

  task automatic check_led(input string tag);
    check(tag, led[7:1], {m_id, m_err, m_rd, m_wr});
  endtask

  // Response scoreboard and hold-under-backpressure checker, sampled mid-cycle.
  always @(negedge clk) begin
    #1;
    if (upd) upd_cnt++;
    if (stall_prev) check("tx_hold", {tx_tvalid, tx_tdata}, {1'b1, held});
    stall_prev = tx_tvalid && !tx_tready;
    held = tx_tdata;
    if (tx_tvalid && tx_tready) begin
      if (exp_q.size() == 0) unexpected++;
      else begin
        check("tx_byte", tx_tdata, exp_q.pop_front());
        check("tx_last", tx_tlast, (tx_idx == 51));
        tx_idx = (tx_idx == 51) ? 0 : tx_idx + 1;
      end
    end
  end

  task automatic build_hdr(input logic [47:0] dst, input logic [47:0] src,
                           input logic [7:0] t0, input logic [7:0] o0, input logic [7:0] o1,
                           input logic [31:0] id);
    for (int i = 0; i < 6; i++) begin
      fb[i]   = dst[8*(5-i) +: 8];
      fb[6+i] = src[8*(5-i) +: 8];
    end
    fb[12] = 8'h00; fb[13] = 8'h26; fb[14] = 8'h00; fb[15] = 8'h00;
    fb[16] = t0; fb[17] = C_; fb[18] = o0; fb[19] = o1;
    for (int b = 0; b < 4; b++) fb[20+b] = id[8*b +: 8];
    for (int i = 24; i < 64; i++) fb[i] = 8'hAA;
  endtask

  task automatic set_word(input int k, input logic [31:0] w);
    for (int b = 0; b < 4; b++) fb[24+4*k+b] = w[8*b +: 8];
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] d, input bit last);
    int guard = 0;
    rx_tdata = d; rx_tvalid = 1'b1; rx_tlast = last;
    while (!rx_tready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!rx_tready) check("rx_ready_timeout", rx_tready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rx_tvalid = 1'b0; rx_tlast = 1'b0;
  endtask

  task automatic send_frame(input int len);
    for (int i = 0; i < len; i++) send_byte(fb[i], (i == len - 1));
  endtask

  task automatic push_resp(input logic [47:0] dst, input logic [31:0] id);
    for (int i = 0; i < 6; i++) exp_q.push_back(dst[8*(5-i) +: 8]);
    for (int i = 0; i < 6; i++) exp_q.push_back(FPGA_MAC[8*(5-i) +: 8]);
    exp_q.push_back(8'h00); exp_q.push_back(8'h26); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp_q.push_back(C_); exp_q.push_back(C_); exp_q.push_back(R_); exp_q.push_back(R_);
    for (int b = 0; b < 4; b++) exp_q.push_back(id[8*b +: 8]);
    for (int k = 0; k < 7; k++)
      for (int b = 0; b < 4; b++) exp_q.push_back(m_regs[k][8*b +: 8]);
  endtask

  // Send a frame already in fb, then check whether the register bank was loaded.
  task automatic run_write(input string tag, input int len, input bit applied, input bit err);
    send_frame(len);
    if (applied) begin
      for (int k = 0; k < 7; k++)
        m_regs[k] = {fb[27+4*k], fb[26+4*k], fb[25+4*k], fb[24+4*k]};
      m_id = fb[20][3:0];
      m_wr = ~m_wr;
      exp_upd++;
    end
    if (err) m_err = 1'b1;
    check({tag, "_upd"}, upd, applied);
    check({tag, "_regs"}, regs, pack_regs());
    @(negedge clk);
    check({tag, "_upd_low"}, upd, 1'b0);
    check({tag, "_upd_cnt"}, upd_cnt, exp_upd);
    check_led({tag, "_led"});
  endtask

  task automatic run_read(input string tag, input logic [47:0] src, input logic [31:0] id,
                          input int len, input bit stall);
    build_hdr(FPGA_MAC, src, C_, R_, R_, id);
    set_word(0, 32'hfeedbeef);
    push_resp(src, id);
    m_rd = ~m_rd;
    m_id = id[3:0];
    if (stall) tx_tready = 1'b0;
    send_frame(len);
    check({tag, "_lat1_valid"}, tx_tvalid, 1'b0);
    check({tag, "_rx_ready_low"}, rx_tready, 1'b0);
    @(negedge clk);
    check({tag, "_lat2_valid"}, tx_tvalid, 1'b1);
    if (stall) begin
      repeat (32) @(negedge clk);
      check({tag, "_stall_rx_low"}, rx_tready, 1'b0);
      check({tag, "_stall_left"}, exp_q.size(), 52);
      tx_tready = 1'b1;
    end
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    check({tag, "_drain"}, exp_q.size(), 0);
    @(negedge clk);
    @(negedge clk);
    check({tag, "_rx_ready_high"}, rx_tready, 1'b1);
    check({tag, "_tx_idle"}, tx_tvalid, 1'b0);
    check_led({tag, "_led"});
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_regs", regs, pack_regs());
    check("rst_tx", {tx_tvalid, tx_tlast, tx_tdata}, 10'h0);
    check("rst_upd", upd, 1'b0);
    check("rst_led", led, 8'h00);
    check("rst_rx_ready", rx_tready, 1'b1);

    // Plan write: id 0x4727, reg1 = 0xf6
    build_hdr(FPGA_MAC, HOST_MAC, C_, W_, W_, 32'h4727);
    set_word(0, 32'h0); set_word(1, 32'hf6); set_word(2, 32'hc8); set_word(3, 32'h300);
    set_word(4, 32'h1); set_word(5, 32'h1000); set_word(6, 32'h0);
    run_write("wr_a", 52, 1'b1, 1'b0);
    check("wr_a_reg1", regs[63:32], 32'h000000f6);
    check("wr_a_led_id", led[7:4], 4'h7);

    // Bytes 28-31 = 00 00 7c 92, trailing bytes ignored
    build_hdr(FPGA_MAC, HOST_MAC, C_, W_, W_, 32'h18);
    for (int k = 0; k < 7; k++) set_word(k, 32'h11111111 * (k + 1));
    set_word(1, 32'h927c0000);
    run_write("wr_b", 60, 1'b1, 1'b0);
    check("wr_b_reg1", regs[63:32], 32'h927c0000);

    run_read("rd_a", HOST_MAC, 32'h4, 28, 1'b0);
    run_read("rd_stall", 48'h0a0b0c0d0e0f, 32'h1234_5679, 24, 1'b1);

    // Disabled by dip switch: silently discarded
    dip_sw = 8'h00;
    build_hdr(FPGA_MAC, HOST_MAC, C_, W_, W_, 32'h3);
    for (int k = 0; k < 7; k++) set_word(k, 32'h5555_0000 + k);
    run_write("wr_dip_off", 52, 1'b0, 1'b0);
    dip_sw = 8'h01;

    build_hdr(FPGA_MAC, HOST_MAC, C_, X_, X_, 32'h9);
    run_write("op_unknown", 52, 1'b0, 1'b0);

    build_hdr(48'h5a0102030406, HOST_MAC, C_, W_, W_, 32'h9);
    run_write("wr_bad_mac", 52, 1'b0, 1'b1);

    // Reset in the middle of a write
    build_hdr(FPGA_MAC, HOST_MAC, C_, W_, W_, 32'hA);
    for (int k = 0; k < 7; k++) set_word(k, 32'hdead_0000 + k);
    for (int i = 0; i < 30; i++) send_byte(fb[i], 1'b0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    check("mid_rst_regs", regs, pack_regs());
    check("mid_rst_upd_cnt", upd_cnt, exp_upd);
    check("mid_rst_led", led, 8'h00);

    run_read("rd_after_rst", HOST_MAC, 32'h2, 24, 1'b0);

    // Short write: tlast on byte 40
    build_hdr(FPGA_MAC, HOST_MAC, C_, W_, W_, 32'hB);
    for (int k = 0; k < 7; k++) set_word(k, 32'h7777_0000 + k);
    run_write("wr_short", 41, 1'b0, 1'b1);

    check("tx_unexpected", unexpected, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
